// File: rtl/turret_sprite_fetch.sv
// Turret sprite fetch: per-frame shadowed sprite position, bounding-box test and
// a 3-stage pipeline that turns a VGA pixel coordinate into an opaque/transparent hit.
module turret_sprite_fetch #(
    parameter int         SPR_W     = 32,
    parameter int         SPR_H     = 32,
    parameter logic [7:0] KEY_INDEX = 8'hFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        vsync,
    input  logic        pix_valid,
    input  logic [9:0]  draw_x,
    input  logic [9:0]  draw_y,
    input  logic [9:0]  turret_x,
    input  logic [9:0]  turret_y,
    input  logic [2:0]  turret_dir,
    input  logic        turret_flip,
    input  logic        turret_en,
    output logic [12:0] rom_addr,
    input  logic [7:0]  rom_data,
    output logic [7:0]  pal_index,
    output logic        hit,
    output logic        out_valid
);

    logic        r_vsync_d;
    logic [9:0]  r_sh_x;
    logic [9:0]  r_sh_y;
    logic [2:0]  r_sh_dir;
    logic        r_sh_flip;
    logic        r_sh_en;

    logic [12:0] r_rom_addr;
    logic [2:1]  r_vld_pipe;
    logic [2:1]  r_in_pipe;
    logic [7:0]  r_pal_index;
    logic        r_hit;
    logic        r_out_valid;

    logic        w_vs_edge;
    logic [10:0] w_dx;
    logic [10:0] w_dy;
    logic        w_in_box;
    logic [4:0]  w_col;
    logic [4:0]  w_row;
    logic        w_opaque;

    assign w_vs_edge = vsync & ~r_vsync_d;

    // Zero-extend before subtracting so a pixel left/above the sprite goes negative
    // instead of wrapping into the box.
    assign w_dx = {1'b0, draw_x} - {1'b0, r_sh_x};
    assign w_dy = {1'b0, draw_y} - {1'b0, r_sh_y};

    assign w_in_box = pix_valid & r_sh_en
                    & ~w_dx[10] & (w_dx[9:0] < 10'(SPR_W))
                    & ~w_dy[10] & (w_dy[9:0] < 10'(SPR_H));

    assign w_col    = r_sh_flip ? (5'(SPR_W - 1) - w_dx[4:0]) : w_dx[4:0];
    assign w_row    = w_dy[4:0];
    assign w_opaque = r_in_pipe[2] & (rom_data != KEY_INDEX);

    // Shadows only move on a vsync rising edge so a frame is drawn from one position.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vsync_d <= 1'b0;
            r_sh_x    <= '0;
            r_sh_y    <= '0;
            r_sh_dir  <= '0;
            r_sh_flip <= 1'b0;
            r_sh_en   <= 1'b0;
        end else begin
            r_vsync_d <= vsync;
            if (w_vs_edge) begin
                r_sh_x    <= turret_x;
                r_sh_y    <= turret_y;
                r_sh_dir  <= turret_dir;
                r_sh_flip <= turret_flip;
                r_sh_en   <= turret_en;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rom_addr  <= '0;
            r_vld_pipe  <= '0;
            r_in_pipe   <= '0;
            r_pal_index <= '0;
            r_hit       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            if (pix_valid)
                r_rom_addr <= {r_sh_dir, w_row, w_col};
            r_vld_pipe  <= {r_vld_pipe[1], pix_valid};
            r_in_pipe   <= {r_in_pipe[1], w_in_box};
            r_out_valid <= r_vld_pipe[2];
            r_hit       <= w_opaque;
            r_pal_index <= w_opaque ? rom_data : 8'h00;
        end
    end

    assign rom_addr  = r_rom_addr;
    assign pal_index = r_pal_index;
    assign hit       = r_hit;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_turret_sprite_fetch.sv
// Bench for turret_sprite_fetch: frame-level sprite model plus directed literal checks.
module tb_turret_sprite_fetch;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        vsync;
    logic        pix_valid;
    logic [9:0]  draw_x, draw_y, turret_x, turret_y;
    logic [2:0]  turret_dir;
    logic        turret_flip, turret_en;
    logic [12:0] rom_addr;
    logic [7:0]  rom_data;
    logic [7:0]  pal_index;
    logic        hit, out_valid;

    int errors = 0;
    int checks = 0;
    int hits_seen = 0;

    turret_sprite_fetch #(.SPR_W(32), .SPR_H(32), .KEY_INDEX(8'hFF)) dut (
        .clk(clk), .reset_n(reset_n), .vsync(vsync), .pix_valid(pix_valid),
        .draw_x(draw_x), .draw_y(draw_y), .turret_x(turret_x), .turret_y(turret_y),
        .turret_dir(turret_dir), .turret_flip(turret_flip), .turret_en(turret_en),
        .rom_addr(rom_addr), .rom_data(rom_data), .pal_index(pal_index),
        .hit(hit), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    logic [7:0] rom_mem [8192];
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: sprite box at the frame's latched position, result due 3 cycles later.
    typedef struct {
        bit         chk;
        bit         ov;
        bit         hit;
        logic [7:0] pal;
        logic [12:0] addr;
    } exp_t;

    exp_t m1, m2, m3;
    int   m_sx, m_sy, m_dir;
    bit   m_flip, m_en, m_pvs;
    logic [12:0] m_last;

    initial begin
        m1 = '{0, 0, 0, 8'h00, 13'h0};
        m2 = m1;
        m3 = m1;
    end

    function automatic logic [12:0] addr_of();
        int dx, dy, col;
        dx  = int'(draw_x) - m_sx;
        dy  = int'(draw_y) - m_sy;
        col = m_flip ? 31 - (dx & 31) : (dx & 31);
        return 13'(m_dir * 1024 + (dy & 31) * 32 + col);
    endfunction

    function automatic exp_t predict();
        exp_t e;
        int dx, dy;
        e = '{1, 0, 0, 8'h00, m_last};
        if (pix_valid) begin
            e.ov   = 1;
            e.addr = addr_of();
            dx = int'(draw_x) - m_sx;
            dy = int'(draw_y) - m_sy;
            if (m_en && dx >= 0 && dx < 32 && dy >= 0 && dy < 32 && rom_mem[e.addr] != 8'hFF) begin
                e.hit = 1;
                e.pal = rom_mem[e.addr];
            end
        end
        return e;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m1     <= '{1, 0, 0, 8'h00, 13'h0};
            m2     <= '{1, 0, 0, 8'h00, 13'h0};
            m3     <= '{1, 0, 0, 8'h00, 13'h0};
            m_en   <= 0;
            m_pvs  <= 0;
            m_sx   <= 0;
            m_sy   <= 0;
            m_dir  <= 0;
            m_flip <= 0;
            m_last <= 13'h0;
        end else begin
            m1 <= predict();
            m2 <= m1;
            m3 <= m2;
            if (pix_valid) m_last <= addr_of();
            if (vsync && !m_pvs) begin
                m_sx   <= int'(turret_x);
                m_sy   <= int'(turret_y);
                m_dir  <= int'(turret_dir);
                m_flip <= turret_flip;
                m_en   <= turret_en;
            end
            m_pvs <= vsync;
        end
    end

    always @(negedge clk) begin
        if (m3.chk) begin
            chk("model_out_valid", out_valid, m3.ov);
            chk("model_hit", hit, m3.hit);
            chk("model_pal_index", pal_index, m3.pal);
        end
        if (m1.chk) chk("model_rom_addr", rom_addr, m1.addr);
        if (hit) hits_seen++;
    end

    task automatic frame();
        @(negedge clk) vsync = 1;
        @(negedge clk);
        @(negedge clk) vsync = 0;
        @(negedge clk);
    endtask

    task automatic sac(string nm, int x, int y, int ea, int eh, int ep);
        @(negedge clk);
        draw_x = 10'(x); draw_y = 10'(y); pix_valid = 1;
        @(negedge clk);
        pix_valid = 0;
        chk({nm, "_addr"}, rom_addr, ea);
        @(negedge clk);
        @(negedge clk);
        chk({nm, "_valid"}, out_valid, 1);
        chk({nm, "_hit"}, hit, eh);
        chk({nm, "_pal"}, pal_index, ep);
    endtask

    task automatic stream(int n, int pct, int vs_at);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pix_valid = ($urandom_range(0, 99) < pct);
            draw_x = 10'(int'(turret_x) + int'($urandom_range(0, 40)) - 4);
            draw_y = 10'(int'(turret_y) + int'($urandom_range(0, 40)) - 4);
            vsync  = (i == vs_at || i == vs_at + 1);
            if (i == vs_at - 2) begin
                turret_x    = turret_x + 10'd7;
                turret_flip = ~turret_flip;
            end
        end
    endtask

    int h0;

    initial begin
        reset_n = 0; vsync = 0; pix_valid = 0;
        draw_x = 0; draw_y = 0; turret_x = 0; turret_y = 0;
        turret_dir = 0; turret_flip = 0; turret_en = 0; rom_data = 0;
        for (int i = 0; i < 8192; i++) rom_mem[i] = 8'((i * 7) ^ (i >> 5));
        rom_mem[13'h0C00] = 8'h05;
        rom_mem[13'h0FFF] = 8'h42;
        rom_mem[13'h0C1F] = 8'hFF;
        rom_mem[13'h0C03] = 8'h33;

        repeat (2) @(negedge clk);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_hit", hit, 0);
        chk("rst_pal", pal_index, 0);
        @(negedge clk) reset_n = 1;

        turret_x = 100; turret_y = 50; turret_dir = 3; turret_flip = 0; turret_en = 1;
        frame();
        sac("origin", 100, 50, 'h0C00, 1, 'h05);
        sac("corner", 131, 81, 'h0FFF, 1, 'h42);
        sac("right_out", 132, 50, 'h0C00, 0, 0);
        sac("left_out", 99, 50, 'h0C1F, 0, 0);

        turret_flip = 1;
        frame();
        sac("flip_key", 100, 50, 'h0C1F, 0, 0);
        sac("flip_edge", 131, 50, 'h0C00, 1, 'h05);

        turret_x = 200; turret_flip = 0;
        sac("old_pos", 131, 50, 'h0C00, 1, 'h05);
        sac("old_pos_far", 200, 50, 'h0C1B, 0, 0);
        frame();
        sac("new_pos", 200, 50, 'h0C00, 1, 'h05);

        turret_x = 1020;
        frame();
        sac("edge_1023", 1023, 50, 'h0C03, 1, 'h33);
        sac("no_wrap", 3, 50, 'h0C07, 0, 0);

        turret_x = 300; turret_y = 200; turret_dir = 5;
        frame();
        stream(30, 100, 12);
        stream(30, 70, 15);

        stream(20, 80, -10);
        @(posedge clk);
        #2 reset_n = 0;
        #1;
        chk("async_rom_addr", rom_addr, 0);
        chk("async_out_valid", out_valid, 0);
        chk("async_hit", hit, 0);
        chk("async_pal", pal_index, 0);
        @(negedge clk) pix_valid = 0;
        @(negedge clk) reset_n = 1;

        turret_x = 0; turret_y = 0; turret_dir = 2; turret_flip = 0;
        h0 = hits_seen;
        stream(30, 100, -10);
        @(negedge clk) pix_valid = 0;
        repeat (4) @(negedge clk);
        chk("no_hit_after_reset", hits_seen - h0, 0);

        frame();
        stream(30, 90, -10);
        @(negedge clk) pix_valid = 0;
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/turret_sprite_fetch.md
TURRET_SPRITE_FETCH -- requirements
Module: turret_sprite_fetch

Interface
REQ-001 SHALL have parameter SPR_W, default 32, sprite width in pixels (power of 2).
REQ-002 SHALL have parameter SPR_H, default 32, sprite height in pixels (power of 2).
REQ-003 SHALL have parameter KEY_INDEX, default 8'hFF, palette index treated as transparent.
REQ-004 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-005 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port vsync  in  1  frame sync; rising edge marks frame boundary.
REQ-007 SHALL have port pix_valid  in  1  draw_x/draw_y valid this cycle.
REQ-008 SHALL have ports draw_x, draw_y  in  10 each  current VGA pixel coordinate.
REQ-009 SHALL have ports turret_x, turret_y  in  10 each  sprite top-left position.
REQ-010 SHALL have port turret_dir  in  3  rotation frame select 0-7.
REQ-011 SHALL have port turret_flip  in  1  horizontal mirror.
REQ-012 SHALL have port turret_en  in  1  sprite drawn when 1.
REQ-013 SHALL have port rom_addr  out  13  {frame[2:0], row[4:0], col[4:0]} to synchronous sprite ROM.
REQ-014 SHALL have port rom_data  in  8  ROM palette index, valid one cycle after rom_addr is sampled.
REQ-015 SHALL have port pal_index  out  8  index for the downstream palette lookup.
REQ-016 SHALL have port hit  out  1  opaque sprite pixel at this position.
REQ-017 SHALL have port out_valid  out  1  pal_index/hit correspond to a valid input pixel.

Function
REQ-018 SHALL detect the vsync rising edge using a one-cycle registered copy of vsync.
REQ-019 SHALL capture turret_x/y/dir/flip/en into shadow registers on the clock edge following edge detection; the shadows remain constant for the rest of the frame.
REQ-020 SHALL compute dx = draw_x - shadow_x and dy = draw_y - shadow_y in 11-bit two's complement, with no wrap-around.
REQ-021 SHALL define in_box = pix_valid & shadow_en & 0<=dx<SPR_W & 0<=dy<SPR_H; negative or oversize dx/dy SHALL give in_box=0.
REQ-022 SHALL use col = dx[4:0] when flip=0 and col = SPR_W-1-dx[4:0] when flip=1, with row = dy[4:0].
REQ-023 Stage 1: SHALL register rom_addr = {shadow_dir,row,col}, s1_valid = pix_valid, s1_in = in_box; rom_addr SHALL hold its last value when pix_valid=0.
REQ-024 Stage 2: SHALL delay s1_valid and s1_in by one cycle to align with rom_data.
REQ-025 Stage 3: SHALL register out_valid = s2_valid and hit = s2_in & (rom_data != KEY_INDEX); pal_index SHALL equal rom_data when hit=1 and 8'h00 otherwise.
REQ-026 Latency: a pixel presented in cycle N SHALL appear on the outputs in cycle N+3, and a new pixel SHALL be accepted every cycle.
REQ-027 A vsync edge during an in-flight pixel SHALL NOT alter that pixel's address or in_box result, since both are fixed at stage 1.
REQ-028 When pix_valid=0, out_valid SHALL be 0 and hit SHALL be 0 three cycles later.

Reset
REQ-029 Asserting reset_n=0 SHALL immediately clear rom_addr, pal_index, hit, out_valid, all pipeline valids, the shadows (shadow_en=0), and the vsync edge register.
REQ-030 Reset applied mid-frame SHALL discard in-flight pixels, and no hit SHALL occur until the first vsync rising edge after release.

Verification
REQ-031 Pos (100,50), dir 3, en 1, vsync edge; pixel (100,50) -> rom_addr=13'h0C00 in cycle N+1; ROM 8'h05 -> pal_index=05, hit=1 at N+3.
REQ-032 Same setup, pixel (131,81) -> rom_addr={3,31,31}; pixels (132,50) and (99,50) -> hit=0, pal_index=00, out_valid=1.
REQ-033 flip=1, pixel (100,50) -> col=31, i.e. rom_addr[4:0]=5'h1F; ROM returns KEY_INDEX 8'hFF -> hit=0, pal_index=00.
REQ-034 Change turret_x mid-frame without vsync -> outputs still use the old position; after vsync rising edge -> new position used.
REQ-035 Pos x=1020, pixel x=1023 -> hit; pixel x=3 -> no hit (no wrap-around); back-to-back pix_valid stream -> one output per cycle, latency 3.
REQ-036 Assert reset_n mid-stream -> all outputs 0 asynchronously; after release, no hit until the next vsync edge.
